// File: rtl/acc_pkg.sv
// acc_pkg: shared FSM state type and signed saturation bounds for seq_accumulator
// Contents:
//   acc_state_t   - accumulator FSM states
//   sat_max(n)    - largest n-bit two's-complement value
//   sat_min(n)    - smallest n-bit two's-complement value
package acc_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} acc_state_t;
  function automatic longint sat_max(input int n);
    return (64'sd1 <<< (n - 1)) - 64'sd1;
  endfunction
  function automatic longint sat_min(input int n);
    return -(64'sd1 <<< (n - 1));
  endfunction
endpackage

// File: rtl/n_adder.sv
// n_adder: N-bit combinational ripple adder with carry in/out
// Ports:
//   A, B  - N-bit addends
//   c_in  - carry in
//   S     - N-bit sum
//   c_out - carry out of the MSB
module n_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         c_in,
  output logic [N-1:0] S,
  output logic         c_out
);
  assign {c_out, S} = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, c_in};
endmodule

// File: rtl/seq_accumulator.sv
// seq_accumulator: signed block accumulator summing LEN samples per start, with wrap or saturate
// Ports:
//   clk, rstn            - clock, asynchronous active-low reset
//   start                - begins a block (IDLE only)
//   in_valid/in_ready    - sample handshake, in_data is the signed sample
//   out_valid/out_ready  - result handshake, out_sum/out_ovf are the block result
//   busy                 - FSM not idle
module seq_accumulator
  import acc_pkg::*;
#(
  parameter int N   = 8,
  parameter int LEN = 4,
  parameter int SAT = 0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_ovf,
  output logic         busy
);
  localparam int CW = ($clog2(LEN + 1) < 1) ? 1 : $clog2(LEN + 1);
  localparam logic [N-1:0] MAXV = N'(sat_max(N));
  localparam logic [N-1:0] MINV = N'(sat_min(N));
  acc_state_t  r_state;
  logic [N-1:0] r_acc, r_sum;
  logic [CW-1:0] r_cnt;
  logic         r_ovf, r_out_ovf, r_out_valid;
  logic [N-1:0] w_s, w_next;
  logic         w_c_out_unused, w_v, w_last;
  n_adder #(.N(N)) u_add (
    .A    (r_acc),
    .B    (in_data),
    .c_in (1'b0),
    .S    (w_s),
    .c_out(w_c_out_unused)
  );
  // Signed overflow: like-signed operands whose sum flips sign.
  assign w_v    = (r_acc[N-1] == in_data[N-1]) && (w_s[N-1] != r_acc[N-1]);
  assign w_next = (w_v && SAT != 0) ? (r_acc[N-1] ? MINV : MAXV) : w_s;
  assign w_last = r_cnt == CW'(LEN - 1);
  assign in_ready  = r_state == ACCUM;
  assign busy      = r_state != IDLE;
  assign out_valid = r_out_valid;
  assign out_sum   = r_sum;
  assign out_ovf   = r_out_ovf;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_sum       <= '0;
      r_out_ovf   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state <= ACCUM;
          r_acc   <= '0;
          r_cnt   <= '0;
          r_ovf   <= 1'b0;
        end
        ACCUM: if (in_valid) begin
          r_acc <= w_next;
          r_ovf <= r_ovf | w_v;
          r_cnt <= r_cnt + CW'(1);
          // Result registers are loaded together with the final sample so
          // out_valid rises exactly one cycle after the last accept.
          if (w_last) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_sum       <= w_next;
            r_out_ovf   <= r_ovf | w_v;
          end
        end
        DONE: if (out_ready) begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_accumulator.sv
// tb_seq_accumulator: directed and randomized checks of seq_accumulator (wrap and saturate instances)
module tb_seq_accumulator;
  import acc_pkg::*;
  logic clk, rstn, start, in_valid, out_ready;
  logic [7:0] in_data;
  logic rdy0, ov0, of0, bz0, rdy1, ov1, of1, bz1;
  logic [7:0] sum0, sum1;
  int checks = 0;
  int failures = 0;

  seq_accumulator #(.N(8), .LEN(4), .SAT(0)) u0 (
    .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_sum(sum0),
    .out_ovf(of0), .busy(bz0));
  seq_accumulator #(.N(8), .LEN(4), .SAT(1)) u1 (
    .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_sum(sum1),
    .out_ovf(of1), .busy(bz1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Exact-arithmetic reference: each step's true sum, wrapped or clamped to 8 bits.
  function automatic logic [8:0] model(input int q[$], input bit sat);
    int a = 0;
    bit o = 1'b0;
    foreach (q[i]) begin
      int t = a + q[i];
      if (t > int'(sat_max(8)) || t < int'(sat_min(8))) begin
        o = 1'b1;
        if (sat) a = (t > 0) ? int'(sat_max(8)) : int'(sat_min(8));
        else a = (t > 0) ? t - 256 : t + 256;
      end else a = t;
    end
    return {o, 8'(a)};
  endfunction

  task automatic run_block(input int q[$], input int gap, input bit rnd, input int hold,
                           input bit poke, input logic [8:0] e0, input logic [8:0] e1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ready_busy", {rdy0, rdy1, bz0, bz1, ov0, ov1}, 6'b111100);
    foreach (q[i]) begin
      int g = rnd ? int'($urandom_range(0, 2)) : ((i == 0) ? 0 : gap);
      in_valid = 1'b0;
      repeat (g) begin
        @(negedge clk);
        chk("gap_ready_busy", {rdy0, rdy1, bz0, bz1, ov0, ov1}, 6'b111100);
      end
      in_valid = 1'b1;
      in_data = 8'(q[i]);
      @(negedge clk);
      if (i != q.size() - 1) chk("no_early_valid", {ov0, ov1, bz0, bz1}, 4'b0011);
    end
    in_valid = 1'b0;
    in_data = 8'($urandom);
    chk("done_flags", {ov0, ov1, rdy0, rdy1, bz0, bz1}, 6'b110011);
    chk("sum_wrap", {of0, sum0}, e0);
    chk("sum_sat", {of1, sum1}, e1);
    repeat (hold) begin
      start = poke;
      in_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b0;
      chk("hold_flags", {ov0, ov1, rdy0, rdy1}, 4'b1100);
      chk("hold_results", {of0, sum0, of1, sum1}, {e0, e1});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release", {ov0, ov1, bz0, bz1, rdy0, rdy1}, 6'b000000);
    chk("release_keep", {of0, sum0, of1, sum1}, {e0, e1});
  endtask

  initial begin
    int q[$];
    logic [8:0] m0, m1;
    rstn = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", {rdy0, ov0, of0, bz0, sum0, rdy1, ov1, of1, bz1, sum1}, '0);
    rstn = 1'b1;
    @(negedge clk);
    run_block('{5, 10, -3, 7}, 0, 1'b0, 0, 1'b0, {1'b0, 8'd19}, {1'b0, 8'd19});
    run_block('{100, 50, 0, 0}, 0, 1'b0, 1, 1'b0, {1'b1, 8'h96}, {1'b1, 8'h7f});
    run_block('{-128, -1, 0, 0}, 0, 1'b0, 1, 1'b0, {1'b1, 8'h7f}, {1'b1, 8'h80});
    run_block('{5, 10, -3, 7}, 2, 1'b0, 3, 1'b1, {1'b0, 8'd19}, {1'b0, 8'd19});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'd20;
    @(negedge clk);
    in_data = 8'd30;
    @(negedge clk);
    in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("async_reset", {rdy0, ov0, of0, bz0, sum0, rdy1, ov1, of1, bz1, sum1}, '0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", {bz0, bz1, rdy0, rdy1}, 4'b0000);
    run_block('{1, 2, 3, 4}, 0, 1'b0, 0, 1'b0, {1'b0, 8'd10}, {1'b0, 8'd10});
    for (int b = 0; b < 50; b++) begin
      q.delete();
      for (int k = 0; k < 4; k++) begin
        logic [7:0] r = 8'($urandom);
        q.push_back(int'($signed(r)));
      end
      m0 = model(q, 1'b0);
      m1 = model(q, 1'b1);
      run_block(q, 0, 1'b1, int'($urandom_range(0, 3)), 1'(b % 2), m0, m1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_accumulator.md
# seq_accumulator

Sequential signed accumulator that sums a block of `LEN` N-bit two's-complement samples, one per accepted handshake, and emits one result per block. It sits directly downstream of the operand source and wraps a single `n_adder` instance as its datapath. The `n_adder` instance has ports `A`, `B`, `c_in`, `S` and `c_out`, and parameter `N`. The running sum is registered here, so the block turns the combinational adder into a multi-cycle reduction stage with valid/ready flow control.

## Interface
- `N`, default 8: sample and sum width in bits (signed).
- `LEN`, default 4: samples per block, ≥1.
- `SAT`, default 0: 0 = wrap on overflow, 1 = saturate to the signed min/max.

- `clk`  in  1  rising-edge clock; single clock domain.
- `rstn`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle pulse that begins a block; honoured only in IDLE.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts a sample this cycle.
- `in_data`  in  N  signed sample.
- `out_valid`  out  1  `out_sum` and `out_ovf` are valid.
- `out_ready`  in  1  consumer takes the result.
- `out_sum`  out  N  signed block sum.
- `out_ovf`  out  1  sticky: at least one signed overflow occurred in this block.
- `busy`  out  1  state ≠ IDLE.

## Operation
- **States and transitions:**
  - IDLE → ACCUM when `start`=1.
  - ACCUM → DONE on the accept that makes `cnt` = LEN (that is, the accept with `cnt` = LEN-1).
  - DONE → IDLE when `out_ready`=1.
- **Accept:** a sample is accepted when `in_valid && in_ready`. `in_ready` = (state==ACCUM), driven combinationally from state only; it does not depend on `in_valid`.
- **On `start` (from IDLE):**
  - `acc` ← 0, `cnt` ← 0, `ovf` ← 0.
  - The result registers (`out_sum`, `out_ovf`) hold their previous values until the next DONE.
- **On each accept:**
  - Adder inputs: `A` = `acc`, `B` = `in_data`, `c_in` = 0.
  - Overflow detect: `v` = (A[N-1]==B[N-1]) && (S[N-1]!=A[N-1]). `c_out` is ignored for signed results.
  - `acc` ← S if `v`=0 or SAT=0.
  - If `v`=1 and SAT=1: `acc` ← 2^(N-1)-1 when A[N-1]=0, else −2^(N-1).
  - `ovf` ← `ovf` | `v`.
  - `cnt` ← `cnt`+1; `cnt` has width max(1, $clog2(LEN+1)).
- **Output in DONE:**
  - `out_valid`=1; `out_sum`=`acc`; `out_ovf`=`ovf`.
  - These hold stable until `out_ready`.
- **Ignored inputs:**
  - `start` outside IDLE has no effect.
  - `in_valid` outside ACCUM is ignored; no sample is consumed.
- **LEN=1:** ACCUM → DONE on the first accept.

## Timing
- **Reset (`rstn` low, asynchronous, any state including mid-block):**
  - State=IDLE; `acc`, `cnt`, `ovf` = 0.
  - `in_ready`=0, `out_valid`=0, `out_sum`=0, `out_ovf`=0, `busy`=0.
  - A partial block is discarded.
- **Start:** `start` sampled high at edge k → `in_ready`=1 and `busy`=1 from cycle k+1.
- **Throughput:** one sample per cycle while `in_valid` is held high. Gaps in `in_valid` stall `cnt` and `acc`.
- **Result latency:** last accept at edge k → `out_valid`=1 in cycle k+1 (one cycle after the final accept). `in_ready`=0 in the same cycle.
- **Release:** `out_ready` high at edge j while `out_valid`=1 → `out_valid`=0 and state=IDLE at j+1.
- **Back-to-back blocks:** `start` can be accepted at j+1 at the earliest. The minimum block period is LEN+2 cycles.
- **Adder path:** `n_adder` is purely combinational inside the acc→acc register loop. The critical path is `acc`→adder→saturation mux→`acc`.

## Structure
- **Package `acc_pkg`:**
  - `typedef enum logic [1:0] {IDLE, ACCUM, DONE} acc_state_t`.
  - Functions `sat_max(N)` / `sat_min(N)` (or equivalent localparams), so the bench and RTL share the saturation bounds.
- **Sub-module:** exactly one `n_adder #(.N(N))` instance.
  - All registers, the FSM, the overflow detect and the saturation mux live in `seq_accumulator`.
- **Size:** about 150 lines of RTL.

## Test plan
All scenarios use N=8, LEN=4.
- **Basic sum:** SAT=0; start, then feed 5, 10, −3, 7 on consecutive cycles → `out_valid` one cycle after the 4th accept; `out_sum`=19, `out_ovf`=0; `busy` is 1 from the cycle after `start` until release.
- **Positive overflow:** feed 100, 50, 0, 0.
  - SAT=0 → `out_sum`=−106, `out_ovf`=1.
  - SAT=1 → `out_sum`=127, `out_ovf`=1.
- **Negative overflow:** feed −128, −1, 0, 0.
  - SAT=0 → `out_sum`=127, `out_ovf`=1.
  - SAT=1 → `out_sum`=−128, `out_ovf`=1.
- **Backpressure and bubbles:** deassert `in_valid` for 2 cycles between samples, hold `out_ready`=0 for 3 cycles in DONE, and pulse `start` during DONE → sum is unaffected by the gaps; `out_sum` and `out_valid` stay stable; `in_ready`=0 throughout DONE; the `start` pulse is ignored.
- **Reset mid-block:** assert `rstn`=0 after 2 accepts → all outputs 0 immediately. After release, start a new block with 1, 2, 3, 4 → `out_sum`=10, `out_ovf`=0.
- **Randomized:** 50 blocks with random samples, random `in_valid`/`out_ready` gaps and SAT∈{0,1} → `out_sum`/`out_ovf` match a golden model that computes the 10-bit exact sum with per-step wrap or clamp.
